// File: rtl/execute_unit.sv
// rtl/execute_unit.sv - OP_IMM/LUI/AUIPC execute stage with register file and optional serial shifter
package Types;
  typedef enum logic [1:0] {
    OK_OP_IMM  = 2'd0,
    OK_LUI     = 2'd1,
    OK_AUIPC   = 2'd2,
    OK_UNKNOWN = 2'd3
  } t_op_kind;

  typedef enum logic [3:0] {
    FK_ADD  = 4'd0,
    FK_SUB  = 4'd1,
    FK_SLT  = 4'd2,
    FK_SLTU = 4'd3,
    FK_AND  = 4'd4,
    FK_OR   = 4'd5,
    FK_XOR  = 4'd6,
    FK_SLL  = 4'd7,
    FK_SRL  = 4'd8,
    FK_SRA  = 4'd9
  } t_func_kind;

  typedef struct packed {
    t_func_kind  func;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] immediate_value;
  } t_op_imm_instr;

  // Padded so both union members have the same width.
  typedef struct packed {
    logic [8:0]  reserved;
    logic [4:0]  rd;
    logic [31:0] immediate_value;
  } t_op_lui_instr;

  typedef union packed {
    t_op_imm_instr op_imm_instr;
    t_op_lui_instr op_lui_instr;
  } t_instr_data;

  typedef struct packed {
    t_op_kind    kind;
    t_instr_data instr_data;
  } t_decoded_instr;
endpackage

module execute_unit #(
  parameter int SERIAL_SHIFT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  Types::t_decoded_instr in_instr,
  input  logic [31:0]           in_pc,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [31:0]           wb_data,
  output logic                  illegal,
  input  logic [4:0]            dbg_addr,
  output logic [31:0]           dbg_data
);
  import Types::*;

  typedef enum logic {S_IDLE = 1'b0, S_SHIFT = 1'b1} t_state;

  t_state        state;
  logic [31:0]   regs [32];

  // Serial shifter context, captured on the accept edge.
  logic [31:0]   acc;
  logic [31:0]   acc_next;
  logic [4:0]    cnt;
  logic [4:0]    sh_rd;
  t_func_kind    sh_func;

  t_op_imm_instr op;
  logic [31:0]   rs1_val;
  logic [4:0]    shamt;
  logic [31:0]   result;
  logic [4:0]    dest;
  logic          legal;
  logic          is_shift;
  logic          accept;
  logic          start_serial;

  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata;

  assign in_ready     = (state == S_IDLE);
  assign accept       = in_valid && in_ready;
  assign start_serial = legal && is_shift && (SERIAL_SHIFT != 0) && (shamt != 5'd0);
  assign dbg_data     = (dbg_addr == 5'd0) ? 32'd0 : regs[dbg_addr];

  // Decode and single-cycle compute of the presented instruction.
  always_comb begin
    op       = in_instr.instr_data.op_imm_instr;
    rs1_val  = (op.rs1 == 5'd0) ? 32'd0 : regs[op.rs1];
    shamt    = op.immediate_value[4:0];
    result   = 32'd0;
    dest     = op.rd;
    legal    = 1'b1;
    is_shift = 1'b0;
    case (in_instr.kind)
      OK_OP_IMM: begin
        case (op.func)
          FK_ADD:  result = rs1_val + op.immediate_value;
          FK_SUB:  result = rs1_val - op.immediate_value;
          FK_SLT:  result = {31'd0, $signed(rs1_val) < $signed(op.immediate_value)};
          FK_SLTU: result = {31'd0, rs1_val < op.immediate_value};
          FK_AND:  result = rs1_val & op.immediate_value;
          FK_OR:   result = rs1_val | op.immediate_value;
          FK_XOR:  result = rs1_val ^ op.immediate_value;
          FK_SLL: begin
            result   = rs1_val << shamt;
            is_shift = 1'b1;
          end
          FK_SRL: begin
            result   = rs1_val >> shamt;
            is_shift = 1'b1;
          end
          FK_SRA: begin
            result   = $unsigned($signed(rs1_val) >>> shamt);
            is_shift = 1'b1;
          end
          default: legal = 1'b0;
        endcase
      end
      OK_LUI: begin
        result = in_instr.instr_data.op_lui_instr.immediate_value;
        dest   = in_instr.instr_data.op_lui_instr.rd;
      end
      OK_AUIPC: begin
        result = in_pc + in_instr.instr_data.op_lui_instr.immediate_value;
        dest   = in_instr.instr_data.op_lui_instr.rd;
      end
      default: legal = 1'b0;
    endcase
  end

  // One-bit step of the serial shifter.
  always_comb begin
    case (sh_func)
      FK_SLL:  acc_next = {acc[30:0], 1'b0};
      FK_SRL:  acc_next = {1'b0, acc[31:1]};
      default: acc_next = {acc[31], acc[31:1]};
    endcase
  end

  // Single register-file write port; x0 is never written.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = dest;
    rf_wdata = result;
    if (state == S_SHIFT) begin
      rf_we    = (cnt == 5'd1) && (sh_rd != 5'd0);
      rf_waddr = sh_rd;
      rf_wdata = acc_next;
    end else begin
      rf_we = accept && legal && !start_serial && (dest != 5'd0);
    end
  end

  for (genvar g = 0; g < 32; g++) begin : g_regs
    // Register g: cleared on reset, loaded when the write port targets it.
    always_ff @(posedge clk) begin
      if (rst) begin
        regs[g] <= 32'd0;
      end else if (rf_we && (rf_waddr == 5'(g))) begin
        regs[g] <= rf_wdata;
      end
    end
  end

  // Control FSM with registered writeback and illegal reports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      acc      <= 32'd0;
      cnt      <= 5'd0;
      sh_rd    <= 5'd0;
      sh_func  <= FK_ADD;
      wb_valid <= 1'b0;
      wb_rd    <= 5'd0;
      wb_data  <= 32'd0;
      illegal  <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      illegal  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (!legal) begin
              illegal <= 1'b1;
            end else if (start_serial) begin
              state   <= S_SHIFT;
              acc     <= rs1_val;
              cnt     <= shamt;
              sh_rd   <= dest;
              sh_func <= op.func;
            end else begin
              wb_valid <= 1'b1;
              wb_rd    <= dest;
              wb_data  <= result;
            end
          end
        end
        S_SHIFT: begin
          acc <= acc_next;
          cnt <= cnt - 5'd1;
          if (cnt == 5'd1) begin
            wb_valid <= 1'b1;
            wb_rd    <= sh_rd;
            wb_data  <= acc_next;
            state    <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_execute_unit.sv
// tb/tb_execute_unit.sv - self-checking bench for execute_unit (serial and barrel shift builds)
module tb_execute_unit;
  import Types::*;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           valid_b;
  logic           in_ready, ready_b;
  t_decoded_instr in_instr;
  logic [31:0]    in_pc;
  logic           wb_valid, wb_valid_b;
  logic [4:0]     wb_rd, wb_rd_b;
  logic [31:0]    wb_data, wb_data_b;
  logic           illegal, illegal_b;
  logic [4:0]     dbg_addr;
  logic [31:0]    dbg_data, dbg_data_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  execute_unit #(.SERIAL_SHIFT(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_data(wb_data), .illegal(illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  execute_unit #(.SERIAL_SHIFT(0)) dut_b (
    .clk(clk), .rst(rst), .in_valid(valid_b), .in_ready(ready_b),
    .in_instr(in_instr), .in_pc(in_pc), .wb_valid(wb_valid_b), .wb_rd(wb_rd_b),
    .wb_data(wb_data_b), .illegal(illegal_b), .dbg_addr(dbg_addr), .dbg_data(dbg_data_b)
  );

  typedef struct {
    t_op_kind    kind;
    t_func_kind  func;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [31:0] imm;
    logic [31:0] pc;
    int          lat;
    logic        ill;
    logic [31:0] data;
    string       name;
  } vec_t;

  vec_t        tbl[$];
  logic [31:0] model_regs [32];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic t_decoded_instr make_instr(input t_op_kind kind, input t_func_kind func,
                                                input logic [4:0] rd, input logic [4:0] rs1,
                                                input logic [31:0] imm);
    t_decoded_instr d;
    d = '0;
    d.kind = kind;
    if (kind == OK_LUI || kind == OK_AUIPC) begin
      d.instr_data.op_lui_instr.rd              = rd;
      d.instr_data.op_lui_instr.immediate_value = imm;
    end else begin
      d.instr_data.op_imm_instr.func            = func;
      d.instr_data.op_imm_instr.rd              = rd;
      d.instr_data.op_imm_instr.rs1             = rs1;
      d.instr_data.op_imm_instr.immediate_value = imm;
    end
    return d;
  endfunction

  task automatic add_vec(input t_op_kind kind, input t_func_kind func, input logic [4:0] rd,
                         input logic [4:0] rs1, input logic [31:0] imm, input logic [31:0] pc,
                         input int lat, input logic ill, input logic [31:0] data, input string name);
    vec_t v;
    v.kind = kind; v.func = func; v.rd = rd; v.rs1 = rs1; v.imm = imm; v.pc = pc;
    v.lat = lat; v.ill = ill; v.data = data; v.name = name;
    tbl.push_back(v);
  endtask

  // Entered and left at a falling edge. Expects the report exactly lat cycles after accept.
  task automatic run_instr(input bit use_b, input t_decoded_instr ins, input logic [31:0] pc,
                           input int lat, input logic ill, input logic [4:0] erd,
                           input logic [31:0] edata, input string name);
    in_instr = ins;
    in_pc    = pc;
    in_valid = !use_b;
    valid_b  = use_b;
    check({name, " ready"}, 32'(use_b ? ready_b : in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    valid_b  = 1'b0;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (c < lat) begin
        check({name, " busy"},
              32'(use_b ? {ready_b, wb_valid_b, illegal_b} : {in_ready, wb_valid, illegal}),
              32'd0);
      end
    end
    check({name, " wb_valid"}, 32'(use_b ? wb_valid_b : wb_valid), 32'(!ill));
    check({name, " illegal"}, 32'(use_b ? illegal_b : illegal), 32'(ill));
    if (!ill) begin
      check({name, " wb_rd"}, 32'(use_b ? wb_rd_b : wb_rd), 32'(erd));
      check({name, " wb_data"}, use_b ? wb_data_b : wb_data, edata);
    end
  endtask

  // Reference semantics of one instruction for the serial-shift build.
  task automatic ref_exec(input t_op_kind k, input logic [3:0] f, input logic [31:0] a,
                          input logic [31:0] imm, input logic [31:0] pc,
                          output logic ok, output logic [31:0] r, output int lat);
    int sh;
    ok  = 1'b1;
    r   = 32'd0;
    lat = 1;
    sh  = int'(imm % 32);
    if (k == OK_LUI) begin
      r = imm;
    end else if (k == OK_AUIPC) begin
      r = pc + imm;
    end else if (k == OK_OP_IMM) begin
      case (f)
        4'd0: r = a + imm;
        4'd1: r = a - imm;
        4'd2: r = (int'(a) < int'(imm)) ? 32'd1 : 32'd0;
        4'd3: r = (a < imm) ? 32'd1 : 32'd0;
        4'd4: r = a & imm;
        4'd5: r = a | imm;
        4'd6: r = a ^ imm;
        4'd7: r = a * (32'd1 << sh);
        4'd8: r = a / (32'd1 << sh);
        4'd9: r = 32'(int'(a) >>> sh);
        default: ok = 1'b0;
      endcase
      if (ok && f >= 4'd7 && sh != 0) lat = sh + 1;
    end else begin
      ok = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw;
    rst      = 1'b1;
    in_valid = 1'b0;
    valid_b  = 1'b0;
    in_instr = '0;
    in_pc    = 32'd0;
    dbg_addr = 5'd0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset wb_valid", 32'(wb_valid), 32'd0);
    check("reset illegal", 32'(illegal), 32'd0);
    check("reset wb_rd", 32'(wb_rd), 32'd0);
    check("reset wb_data", wb_data, 32'd0);
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("reset dbg x%0d", i), dbg_data, 32'd0);
    end

    add_vec(OK_OP_IMM, FK_ADD,  5'd1,  5'd0, 32'd5,          32'd0,    1,  1'b0, 32'd5,          "addi x1");
    add_vec(OK_OP_IMM, FK_ADD,  5'd2,  5'd1, 32'hFFFFFFFF,   32'd0,    1,  1'b0, 32'd4,          "addi x2 dep");
    add_vec(OK_LUI,    FK_ADD,  5'd3,  5'd0, 32'h12345000,   32'd0,    1,  1'b0, 32'h12345000,   "lui x3");
    add_vec(OK_AUIPC,  FK_ADD,  5'd4,  5'd0, 32'h00001000,   32'h80,   1,  1'b0, 32'h00001080,   "auipc x4");
    add_vec(OK_OP_IMM, FK_SLT,  5'd5,  5'd1, 32'hFFFFFFFF,   32'd0,    1,  1'b0, 32'd0,          "slti x5");
    add_vec(OK_OP_IMM, FK_SLTU, 5'd6,  5'd1, 32'hFFFFFFFF,   32'd0,    1,  1'b0, 32'd1,          "sltiu x6");
    add_vec(OK_OP_IMM, FK_XOR,  5'd7,  5'd1, 32'hFFFFFFFF,   32'd0,    1,  1'b0, 32'hFFFFFFFA,   "xori x7");
    add_vec(OK_LUI,    FK_ADD,  5'd8,  5'd0, 32'h80000000,   32'd0,    1,  1'b0, 32'h80000000,   "lui x8");
    add_vec(OK_OP_IMM, FK_SRA,  5'd9,  5'd8, 32'd4,          32'd0,    5,  1'b0, 32'hF8000000,   "srai x9 serial");
    add_vec(OK_OP_IMM, FK_SLL,  5'd10, 5'd1, 32'd0,          32'd0,    1,  1'b0, 32'd5,          "slli shamt0");
    add_vec(OK_OP_IMM, FK_SRL,  5'd11, 5'd8, 32'd31,         32'd0,    32, 1'b0, 32'd1,          "srli 31");
    add_vec(OK_OP_IMM, FK_SUB,  5'd12, 5'd1, 32'd6,          32'd0,    1,  1'b0, 32'hFFFFFFFF,   "sub x12");
    add_vec(OK_OP_IMM, FK_AND,  5'd13, 5'd3, 32'hFFF0F000,   32'd0,    1,  1'b0, 32'h12305000,   "andi x13");
    add_vec(OK_OP_IMM, FK_OR,   5'd14, 5'd1, 32'h30,         32'd0,    1,  1'b0, 32'h35,         "ori x14");
    add_vec(OK_OP_IMM, FK_SLL,  5'd15, 5'd1, 32'd3,          32'd0,    4,  1'b0, 32'd40,         "slli x15 serial");
    add_vec(OK_OP_IMM, FK_ADD,  5'd0,  5'd0, 32'd7,          32'd0,    1,  1'b0, 32'd7,          "addi x0");
    add_vec(OK_UNKNOWN, FK_ADD, 5'd16, 5'd1, 32'd1,          32'd0,    1,  1'b1, 32'd0,          "unknown kind");
    add_vec(OK_OP_IMM, t_func_kind'(4'd12), 5'd17, 5'd1, 32'd1, 32'd0, 1,  1'b1, 32'd0,          "bad func");

    for (int i = 0; i < tbl.size(); i++) begin
      run_instr(1'b0, make_instr(tbl[i].kind, tbl[i].func, tbl[i].rd, tbl[i].rs1, tbl[i].imm),
                tbl[i].pc, tbl[i].lat, tbl[i].ill, tbl[i].rd, tbl[i].data, tbl[i].name);
    end

    dbg_addr = 5'd0;  #1; check("dbg x0 after addi x0", dbg_data, 32'd0);
    dbg_addr = 5'd2;  #1; check("dbg x2", dbg_data, 32'd4);
    dbg_addr = 5'd9;  #1; check("dbg x9", dbg_data, 32'hF8000000);
    dbg_addr = 5'd16; #1; check("dbg x16 untouched", dbg_data, 32'd0);
    dbg_addr = 5'd17; #1; check("dbg x17 untouched", dbg_data, 32'd0);

    run_instr(1'b1, make_instr(OK_LUI, FK_ADD, 5'd8, 5'd0, 32'h80000000), 32'd0, 1, 1'b0,
              5'd8, 32'h80000000, "b lui x8");
    run_instr(1'b1, make_instr(OK_OP_IMM, FK_SRA, 5'd9, 5'd8, 32'd4), 32'd0, 1, 1'b0,
              5'd9, 32'hF8000000, "b srai x9");
    run_instr(1'b1, make_instr(OK_OP_IMM, FK_SRL, 5'd11, 5'd8, 32'd31), 32'd0, 1, 1'b0,
              5'd11, 32'd1, "b srli x11");
    run_instr(1'b1, make_instr(OK_OP_IMM, FK_SLL, 5'd12, 5'd9, 32'd2), 32'd0, 1, 1'b0,
              5'd12, 32'hE0000000, "b slli x12");
    dbg_addr = 5'd9; #1; check("b dbg x9", dbg_data_b, 32'hF8000000);

    in_instr = make_instr(OK_OP_IMM, FK_SRA, 5'd20, 5'd8, 32'd8);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort busy", 32'(in_ready), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (wb_valid) saw = 1'b1;
    end
    check("abort no wb", 32'(saw), 32'd0);
    check("abort ready", 32'(in_ready), 32'd1);
    dbg_addr = 5'd20; #1; check("abort dest", dbg_data, 32'd0);

    for (int i = 0; i < 32; i++) model_regs[i] = 32'd0;
    for (int n = 0; n < 150; n++) begin
      t_op_kind    k;
      t_func_kind  f;
      logic [4:0]  rd, rs1;
      logic [31:0] imm, pc, a, r;
      logic        ok;
      int          lat, sel;
      sel = int'($urandom_range(0, 9));
      k   = (sel <= 6) ? OK_OP_IMM : (sel == 7) ? OK_LUI : (sel == 8) ? OK_AUIPC : OK_UNKNOWN;
      f   = t_func_kind'(4'($urandom_range(0, 11)));
      rd  = 5'($urandom_range(0, 31));
      rs1 = 5'($urandom_range(0, 31));
      imm = $urandom;
      pc  = $urandom & 32'hFFFFFFFC;
      a   = (rs1 == 5'd0) ? 32'd0 : model_regs[rs1];
      ref_exec(k, f, a, imm, pc, ok, r, lat);
      run_instr(1'b0, make_instr(k, f, rd, rs1, imm), pc, lat, !ok, rd, r,
                $sformatf("rand%0d", n));
      if (ok && rd != 5'd0) model_regs[rd] = r;
    end
    for (int i = 0; i < 32; i++) begin
      dbg_addr = 5'(i);
      #1;
      check($sformatf("final dbg x%0d", i), dbg_data, (i == 0) ? 32'd0 : model_regs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
